// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA dot overlay path.
package vga_pkg;

  localparam int unsigned VIDEO_WIDTH  = 640;
  localparam int unsigned VIDEO_HEIGHT = 480;
  localparam int unsigned COLOR_W      = 12;
  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 9;

  typedef struct packed {
    logic           vld;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } dot_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/vga_box_hit.sv
// Square box hit test; edge sums are one bit wider so boxes near the screen edge clip instead of wrapping.
module vga_box_hit #(
  parameter int unsigned SIZE = 2,
  parameter int unsigned X_W  = 10,
  parameter int unsigned Y_W  = 9
) (
  input  logic           en,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  output logic           hit_c
);

  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  assign x_end = {1'b0, bx} + (X_W+1)'(SIZE);
  assign y_end = {1'b0, by} + (Y_W+1)'(SIZE);

  assign hit_c = en
              && (px >= bx) && ({1'b0, px} < x_end)
              && (py >= by) && ({1'b0, py} < y_end);

endmodule

// File: rtl/vga_dot_overlay.sv
// Draws NUM_DOTS dots and a goal box over the background; the shadow table is copied to the
// active table in vertical blank. Optional VGA_DOT_COLLISION_EN adds collision_count/goal_reached.
module vga_dot_overlay #(
  parameter int unsigned NUM_DOTS  = 16,
  parameter int unsigned DOT_SIZE  = 2,
  parameter int unsigned GOAL_SIZE = 20,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned COLOR_W   = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_en,
  input  logic                        active_in,
  input  logic                        screen_end,
  input  logic [X_W-1:0]              x,
  input  logic [Y_W-1:0]              y,
  input  logic [COLOR_W-1:0]          bg_color,
  input  logic [X_W-1:0]              goal_x,
  input  logic [Y_W-1:0]              goal_y,
  input  logic [COLOR_W-1:0]          dot_color,
  input  logic [COLOR_W-1:0]          goal_color,
  input  logic                        wr_en,
  output logic                        wr_ready,
  input  logic [$clog2(NUM_DOTS)-1:0] wr_idx,
  input  logic [X_W-1:0]              wr_x,
  input  logic [Y_W-1:0]              wr_y,
  input  logic                        wr_vld,
  input  logic                        commit,
  output logic                        commit_pending,
  output logic                        frame_done,
  output logic [COLOR_W-1:0]          rgb_out,
`ifdef VGA_DOT_COLLISION_EN
  output logic                        dot_hit,
  output logic [$clog2(NUM_DOTS):0]   collision_count,
  output logic                        goal_reached
`else
  output logic                        dot_hit
`endif
);

  import vga_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_DOTS);

  dot_entry_t          shadow [NUM_DOTS];
  dot_entry_t          active [NUM_DOTS];
  logic [NUM_DOTS-1:0] dot_hits_c;
  logic                goal_hit_c;
  logic                any_hit_c;

  fsm_state_t          state_q, state_d;
  logic [IDX_W-1:0]    copy_idx_q;
  logic                recommit_q, recommit_d;
  logic                frame_done_d;

  // Per-slot and goal hit comparators against the current pixel
  for (genvar g = 0; g < int'(NUM_DOTS); g++) begin : g_dot
    vga_box_hit #(.SIZE(DOT_SIZE), .X_W(X_W), .Y_W(Y_W)) u_hit (
      .en   (active[g].vld),
      .px   (x),
      .py   (y),
      .bx   (active[g].x),
      .by   (active[g].y),
      .hit_c(dot_hits_c[g])
    );
  end

  vga_box_hit #(.SIZE(GOAL_SIZE), .X_W(X_W), .Y_W(Y_W)) u_goal (
    .en   (1'b1),
    .px   (x),
    .py   (y),
    .bx   (goal_x),
    .by   (goal_y),
    .hit_c(goal_hit_c)
  );

  assign any_hit_c = |dot_hits_c;

  // Pixel path: one registered stage that advances on pix_en only
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out <= '0;
      dot_hit <= 1'b0;
    end else if (pix_en) begin
      if (!active_in) begin
        rgb_out <= '0;
        dot_hit <= 1'b0;
      end else if (any_hit_c) begin
        rgb_out <= dot_color;
        dot_hit <= 1'b1;
      end else if (goal_hit_c) begin
        rgb_out <= goal_color;
        dot_hit <= 1'b0;
      end else begin
        rgb_out <= bg_color;
        dot_hit <= 1'b0;
      end
    end
  end

  // Update handshake: commit arms, screen_end starts the copy, copy runs one slot per clk
  always_comb begin
    state_d      = state_q;
    recommit_d   = recommit_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit)     state_d = PENDING;
        if (screen_end) frame_done_d = 1'b1;
      end
      PENDING: begin
        if (screen_end) state_d = COPY;
      end
      COPY: begin
        if (commit) recommit_d = 1'b1;
        if (copy_idx_q == IDX_W'(NUM_DOTS - 1)) begin
          frame_done_d = 1'b1;
          recommit_d   = 1'b0;
          state_d      = (recommit_q || commit) ? PENDING : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      recommit_q     <= 1'b0;
      copy_idx_q     <= '0;
      frame_done     <= 1'b0;
      wr_ready       <= 1'b1;
      commit_pending <= 1'b0;
    end else begin
      state_q        <= state_d;
      recommit_q     <= recommit_d;
      copy_idx_q     <= (state_q == COPY) ? copy_idx_q + IDX_W'(1) : '0;
      frame_done     <= frame_done_d;
      wr_ready       <= (state_d != COPY);
      commit_pending <= (state_d != IDLE);
    end
  end

  // Shadow writes are gated by wr_ready so the table cannot change under the copy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DOTS); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en && wr_ready) begin
        shadow[wr_idx] <= '{vld: wr_vld, x: wr_x, y: wr_y};
      end
      if (state_q == COPY) begin
        active[copy_idx_q] <= shadow[copy_idx_q];
      end
    end
  end

`ifdef VGA_DOT_COLLISION_EN
  logic [NUM_DOTS-1:0] coll_hits_c;
  logic [IDX_W:0]      coll_sum_c;

  // Top-left corner of each valid active dot tested against the goal box
  for (genvar g = 0; g < int'(NUM_DOTS); g++) begin : g_coll
    vga_box_hit #(.SIZE(GOAL_SIZE), .X_W(X_W), .Y_W(Y_W)) u_coll (
      .en   (active[g].vld),
      .px   (active[g].x),
      .py   (active[g].y),
      .bx   (goal_x),
      .by   (goal_y),
      .hit_c(coll_hits_c[g])
    );
  end

  always_comb begin
    coll_sum_c = '0;
    for (int i = 0; i < int'(NUM_DOTS); i++) begin
      coll_sum_c = coll_sum_c + (IDX_W+1)'(coll_hits_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_count <= '0;
      goal_reached    <= 1'b0;
    end else if (frame_done) begin
      collision_count <= (coll_sum_c > (IDX_W+1)'(NUM_DOTS)) ? (IDX_W+1)'(NUM_DOTS) : coll_sum_c;
      goal_reached    <= (coll_sum_c != '0);
    end
  end
`endif

endmodule
